uart_tx_buffered: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buffered.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, defaults and width helpers for the buffered UART transmitter.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, read-first: the head is visible combinationally and
// a same-cycle push+pop is accepted even when full.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_n;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // Storage array; no reset needed, contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == FULL_CNT);
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a small input FIFO, paced by a 16x baud tick.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_baud_rate,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_busy,
  output logic                 o_full,
  output logic                 o_overflow
);

  localparam int SW = cnt_w((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int NW = cnt_w(DATA_BITS);
  localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [SW-1:0]        s_cnt, s_cnt_n;
  logic [NW-1:0]        n_cnt, n_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] head;
  logic                 pop, done_n, tx_n;
  logic                 fifo_full, fifo_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_tx_start),
    .pop   (pop),
    .wdata (i_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serialiser next-state: each bit is timed by counting ticks from state entry.
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    shreg_n = shreg;
    pop     = 1'b0;
    done_n  = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = head;
          s_cnt_n = '0;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (i_baud_rate) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_n = '0;
            n_cnt_n = '0;
            state_n = DATA;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (i_baud_rate) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_n = '0;
            shreg_n = shreg >> 1;
            if (n_cnt == N_LAST) state_n = STOP;
            else                 n_cnt_n = n_cnt + 1'b1;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (i_baud_rate) begin
          if (s_cnt == SB_LAST) begin
            s_cnt_n = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs; o_tx trails the state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_cnt      <= '0;
      n_cnt      <= '0;
      shreg      <= '0;
      o_tx       <= 1'b1;
      o_tx_done  <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state     <= state_n;
      s_cnt     <= s_cnt_n;
      n_cnt     <= n_cnt_n;
      shreg     <= shreg_n;
      o_tx      <= tx_n;
      o_tx_done <= done_n;
      o_busy    <= (state != IDLE) || !fifo_empty;
      if (i_tx_start && fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

  assign o_full = fifo_full;

endmodule
